// File: rtl/sample_sched_pkg.sv
// Shared types and defaults for the neck-detection sample scheduler.
// State encoding, default timing parameters and a saturating watchdog increment.
package sample_sched_pkg;

   localparam int DATA_W         = 13;
   localparam int SAMPLE_DIV_DEF = 200;
   localparam int TIMEOUT_DEF    = 150;
   localparam int WARMUP_DEF     = 3;
   localparam int CNT_W_DEF      = 16;
   localparam int PERIOD_W       = 16;
   localparam int WDOG_W         = 16;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ADC = 2'd1,
      S_WAIT_FLT = 2'd2,
      S_WAIT_DIF = 2'd3
   } state_t;

   // Saturates so a late accepted finish can never wrap back onto the abort value.
   function automatic logic [WDOG_W-1:0] wdog_inc(input logic [WDOG_W-1:0] i_w);
      return (i_w == '1) ? i_w : i_w + WDOG_W'(1);
   endfunction

endpackage

// File: rtl/sample_sched_if.sv
// Handshake/status bundle between the scheduler and the processing chain.
// The slave modport is the scheduler's view; the master modport is the chain/controller view.
interface sample_sched_if #(
   parameter int CNT_W = sample_sched_pkg::CNT_W_DEF
) ();

   logic             enable;
   logic             clr_stats;
   logic             adc_finish;
   logic             filter_finish;
   logic             dif_finish;
   logic             en_adc;
   logic             en_judge;
   logic             busy;
   logic             warm;
   logic             timeout_flag;
   logic [CNT_W-1:0] overrun_cnt;
   logic [CNT_W-1:0] timeout_cnt;

   modport slave (
      input  enable, clr_stats, adc_finish, filter_finish, dif_finish,
      output en_adc, en_judge, busy, warm, timeout_flag, overrun_cnt, timeout_cnt
   );

   modport master (
      output enable, clr_stats, adc_finish, filter_finish, dif_finish,
      input  en_adc, en_judge, busy, warm, timeout_flag, overrun_cnt, timeout_cnt
   );

endinterface

// File: rtl/sample_sched_tick_gen.sv
// Sample-period counter: counts 0..SAMPLE_DIV-1 while enabled, held at 0 otherwise.
// o_tick is high during the last count of each period.
module sample_sched_tick_gen
   import sample_sched_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   output logic o_tick
);

   logic [PERIOD_W-1:0] r_cnt;
   logic                w_last;

   assign w_last = (r_cnt == PERIOD_W'(SAMPLE_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_enable || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PERIOD_W'(1);
      end
   end

   assign o_tick = i_enable && w_last;

endmodule

// File: rtl/sample_sched.sv
// Sample-rate scheduler: one ADC start per period, tracks adc/filter/dif completion, gates neck_judge.
// Define SAMPLE_SCHED_STATS_EN to implement the overrun/timeout statistics counters.
module sample_sched
   import sample_sched_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int WARMUP     = WARMUP_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   sample_sched_if.slave io_bus
);

   localparam int WARM_W = $clog2(WARMUP + 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WDOG_W-1:0] r_wdog;
   logic [WARM_W-1:0] r_warm_cnt;
   logic              r_en_adc;
   logic              r_en_judge;
   logic              r_timeout_flag;

   logic w_tick;
   logic w_start;
   logic w_abort;
   logic w_warm;
   logic w_dif_acc;
   logic w_wdog_exp;

   sample_sched_tick_gen #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .i_enable (io_bus.enable),
      .o_tick   (w_tick)
   );

   assign w_wdog_exp = (r_wdog == WDOG_W'(TIMEOUT - 1));
   assign w_warm     = (r_warm_cnt == WARM_W'(WARMUP));

   // An accepted finish in the last watchdog cycle takes priority over the abort.
   always_comb begin
      // NOTE: every combinational output gets a default first so no branch infers a latch.
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_dif_acc   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_start     = 1'b1;
               w_state_nxt = S_WAIT_ADC;
            end
         end
         S_WAIT_ADC: begin
            if (io_bus.adc_finish) w_state_nxt = S_WAIT_FLT;
            else if (w_wdog_exp)   w_abort     = 1'b1;
         end
         S_WAIT_FLT: begin
            if (io_bus.filter_finish) w_state_nxt = S_WAIT_DIF;
            else if (w_wdog_exp)      w_abort     = 1'b1;
         end
         S_WAIT_DIF: begin
            if (io_bus.dif_finish) begin
               w_dif_acc   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_wdog_exp) begin
               w_abort = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_en_adc       <= 1'b0;
         r_en_judge     <= 1'b0;
         r_wdog         <= '0;
         r_warm_cnt     <= '0;
         r_timeout_flag <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_en_adc   <= w_start;
         r_en_judge <= w_dif_acc && w_warm;

         if (w_start)                r_wdog <= '0;
         else if (r_state != S_IDLE) r_wdog <= wdog_inc(r_wdog);

         // History is only trusted across uninterrupted, enabled sampling.
         if ((!io_bus.enable && r_state == S_IDLE) || w_abort) r_warm_cnt <= '0;
         else if (w_dif_acc && !w_warm)                         r_warm_cnt <= r_warm_cnt + WARM_W'(1);

         if (io_bus.clr_stats) r_timeout_flag <= 1'b0;
         else if (w_abort)     r_timeout_flag <= 1'b1;
      end
   end

`ifdef SAMPLE_SCHED_STATS_EN
   logic [CNT_W-1:0] r_overrun_cnt;
   logic [CNT_W-1:0] r_timeout_cnt;
   logic             w_overrun;

   assign w_overrun = w_tick && (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun_cnt <= '0;
         r_timeout_cnt <= '0;
      end else if (io_bus.clr_stats) begin
         r_overrun_cnt <= '0;
         r_timeout_cnt <= '0;
      end else begin
         if (w_overrun && r_overrun_cnt != '1) r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
         if (w_abort && r_timeout_cnt != '1)   r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
      end
   end

   assign io_bus.overrun_cnt = r_overrun_cnt;
   assign io_bus.timeout_cnt = r_timeout_cnt;
`else
   assign io_bus.overrun_cnt = '0;
   assign io_bus.timeout_cnt = '0;
`endif

   assign io_bus.en_adc       = r_en_adc;
   assign io_bus.en_judge     = r_en_judge;
   assign io_bus.busy         = (r_state != S_IDLE);
   assign io_bus.warm         = w_warm;
   assign io_bus.timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_sample_sched.sv
// Directed bench for sample_sched: a 200/150 instance for nominal/stall/control cases and a
// 40/38 instance for overrun cases; counter expectations follow SAMPLE_SCHED_STATS_EN.
module tb_sample_sched;

`ifdef SAMPLE_SCHED_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   int   vectors  = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   prev_adc = 0;
   bit   use_b    = 1'b0;

   sample_sched_if #(.CNT_W(16)) ifa ();
   sample_sched_if #(.CNT_W(16)) ifb ();

   sample_sched #(.SAMPLE_DIV(200), .TIMEOUT(150), .WARMUP(3), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .io_bus(ifa)
   );
   sample_sched #(.SAMPLE_DIV(40), .TIMEOUT(38), .WARMUP(3), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .io_bus(ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic o_adc, o_judge, o_busy, o_warm, o_flag;
   logic [15:0] o_ovr, o_tmo;
   assign o_adc   = use_b ? ifb.en_adc       : ifa.en_adc;
   assign o_judge = use_b ? ifb.en_judge     : ifa.en_judge;
   assign o_busy  = use_b ? ifb.busy         : ifa.busy;
   assign o_warm  = use_b ? ifb.warm         : ifa.warm;
   assign o_flag  = use_b ? ifb.timeout_flag : ifa.timeout_flag;
   assign o_ovr   = use_b ? ifb.overrun_cnt  : ifa.overrun_cnt;
   assign o_tmo   = use_b ? ifb.timeout_cnt  : ifa.timeout_cnt;

   task automatic drive_acks(input logic a, input logic f, input logic d);
      if (use_b) begin
         ifb.adc_finish = a; ifb.filter_finish = f; ifb.dif_finish = d;
      end else begin
         ifa.adc_finish = a; ifa.filter_finish = f; ifa.dif_finish = d;
      end
   endtask

   task automatic set_enable(input logic v);
      if (use_b) ifb.enable = v; else ifa.enable = v;
   endtask

   task automatic set_clr(input logic v);
      if (use_b) ifb.clr_stats = v; else ifa.clr_stats = v;
   endtask

   // Waits for en_adc, then plays one sample: acks at the given cycle offsets (-1 = never).
   // Offset k means the pulse is high during cycle k after en_adc is seen (cycle 0).
   task automatic do_sample(input int a_off, input int f_off, input int d_off, input int sp_off,
                            input int dis_off, input int clr_off, input int lim,
                            output int gap, output int judge_at, output int done_at,
                            output int adc_hi, output logic warm_end);
      int waited;
      gap = -1; judge_at = -1; done_at = -1; adc_hi = 0; warm_end = 1'bx;
      waited = 0;
      while (o_adc !== 1'b1 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (o_adc !== 1'b1) begin
         judge_at = -2; done_at = -2;
         return;
      end
      gap = cyc - prev_adc;
      prev_adc = cyc;
      for (int k = 0; k <= lim; k++) begin
         if (o_judge === 1'b1 && judge_at < 0) judge_at = k;
         if (k > 0 && o_busy === 1'b0 && done_at < 0) begin
            done_at = k;
            warm_end = o_warm;
         end
         if (o_adc === 1'b1) adc_hi++;
         drive_acks(k == a_off, k == f_off, (k == d_off) || (k == sp_off));
         if (k == dis_off) set_enable(1'b0);
         set_clr(k == clr_off);
         @(negedge clk);
      end
      drive_acks(1'b0, 1'b0, 1'b0);
      set_clr(1'b0);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({ifa.en_adc, ifa.en_judge, ifa.busy, ifa.warm, ifa.timeout_flag} !== 5'b0 ||
          ifa.overrun_cnt !== 16'd0 || ifa.timeout_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_a: adc=%b judge=%b busy=%b warm=%b flag=%b ovr=%0d tmo=%0d, want all 0",
                  ifa.en_adc, ifa.en_judge, ifa.busy, ifa.warm, ifa.timeout_flag, ifa.overrun_cnt, ifa.timeout_cnt);
      end
      vectors++;
      if ({ifb.en_adc, ifb.en_judge, ifb.busy, ifb.warm, ifb.timeout_flag} !== 5'b0 ||
          ifb.overrun_cnt !== 16'd0 || ifb.timeout_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_b: adc=%b judge=%b busy=%b warm=%b flag=%b, want all 0",
                  ifb.en_adc, ifb.en_judge, ifb.busy, ifb.warm, ifb.timeout_flag);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      int gap, jdg, done, hi;
      logic wrm;
      use_b = 1'b0;
      set_enable(1'b1);
      prev_adc = cyc;
      for (int s = 1; s <= 4; s++) begin
         do_sample(20, 25, 30, -1, -1, -1, 160, gap, jdg, done, hi, wrm);
         vectors++;
         if (gap !== 200) begin errors++; $display("FAIL nominal_gap s%0d: got %0d want 200", s, gap); end
         vectors++;
         if (hi !== 1) begin errors++; $display("FAIL nominal_adc_width s%0d: got %0d want 1", s, hi); end
         vectors++;
         if (done !== 31) begin errors++; $display("FAIL nominal_done s%0d: got %0d want 31", s, done); end
         vectors++;
         if (jdg !== (s == 4 ? 31 : -1)) begin
            errors++; $display("FAIL nominal_judge s%0d: got %0d want %0d", s, jdg, (s == 4 ? 31 : -1));
         end
         vectors++;
         if (wrm !== (s >= 3)) begin errors++; $display("FAIL nominal_warm s%0d: got %b want %b", s, wrm, (s >= 3)); end
      end
   endtask

   task automatic test_stall();
      int gap, jdg, done, hi;
      logic wrm;
      do_sample(20, -1, 30, -1, -1, -1, 160, gap, jdg, done, hi, wrm);
      vectors++;
      if (done !== 150) begin errors++; $display("FAIL stall_abort_cycle: got %0d want 150", done); end
      vectors++;
      if (jdg !== -1) begin errors++; $display("FAIL stall_judge: got %0d want -1", jdg); end
      vectors++;
      if (wrm !== 1'b0) begin errors++; $display("FAIL stall_warm: got %b want 0", wrm); end
      vectors++;
      if (o_flag !== 1'b1) begin errors++; $display("FAIL stall_flag: got %b want 1", o_flag); end
      vectors++;
      if (o_tmo !== 16'(STATS_ON ? 1 : 0)) begin
         errors++; $display("FAIL stall_timeout_cnt: got %0d want %0d", o_tmo, (STATS_ON ? 1 : 0));
      end
      for (int s = 6; s <= 9; s++) begin
         do_sample(20, 25, 30, -1, -1, -1, 160, gap, jdg, done, hi, wrm);
         vectors++;
         if (gap !== 200) begin errors++; $display("FAIL stall_gap s%0d: got %0d want 200", s, gap); end
         vectors++;
         if (jdg !== (s == 9 ? 31 : -1)) begin
            errors++; $display("FAIL stall_rewarm_judge s%0d: got %0d want %0d", s, jdg, (s == 9 ? 31 : -1));
         end
      end
   endtask

   task automatic test_spurious();
      int gap, jdg, done, hi;
      logic wrm;
      set_clr(1'b1);
      @(negedge clk);
      set_clr(1'b0);
      vectors++;
      if (o_flag !== 1'b0 || o_tmo !== 16'd0) begin
         errors++; $display("FAIL clr_stats: flag=%b tmo=%0d want 0/0", o_flag, o_tmo);
      end
      @(negedge clk);
      // Stray dif at +5 in WAIT_ADC; adc lands exactly on the last watchdog cycle.
      do_sample(149, 155, 160, 5, -1, -1, 170, gap, jdg, done, hi, wrm);
      vectors++;
      if (gap !== 200) begin errors++; $display("FAIL spurious_gap: got %0d want 200", gap); end
      vectors++;
      if (done !== 161) begin errors++; $display("FAIL spurious_done: got %0d want 161", done); end
      vectors++;
      if (jdg !== 161) begin errors++; $display("FAIL spurious_judge: got %0d want 161", jdg); end
      vectors++;
      if (o_flag !== 1'b0) begin errors++; $display("FAIL coincident_no_abort: flag=%b want 0", o_flag); end
   endtask

   task automatic test_enable_drop();
      int gap, jdg, done, hi, n;
      logic wrm;
      do_sample(20, 25, 30, -1, 22, -1, 40, gap, jdg, done, hi, wrm);
      vectors++;
      if (done !== 31 || jdg !== 31) begin
         errors++; $display("FAIL endrop_complete: done=%0d judge=%0d want 31/31", done, jdg);
      end
      vectors++;
      if (o_warm !== 1'b0) begin errors++; $display("FAIL endrop_warm: got %b want 0", o_warm); end
      n = 0;
      repeat (400) begin
         @(negedge clk);
         if (o_adc === 1'b1) n++;
      end
      vectors++;
      if (n !== 0 || o_busy !== 1'b0) begin
         errors++; $display("FAIL endrop_no_start: en_adc pulses=%0d busy=%b want 0/0", n, o_busy);
      end
   endtask

   task automatic test_overrun();
      int gap, jdg, done, hi;
      logic wrm;
      use_b = 1'b1;
      set_enable(1'b1);
      prev_adc = cyc;
      for (int s = 1; s <= 3; s++) begin
         do_sample(37, 45, 50, -1, -1, -1, 60, gap, jdg, done, hi, wrm);
         vectors++;
         if (gap !== (s == 1 ? 40 : 80)) begin
            errors++; $display("FAIL overrun_gap s%0d: got %0d want %0d", s, gap, (s == 1 ? 40 : 80));
         end
         vectors++;
         if (done !== 51) begin errors++; $display("FAIL overrun_done s%0d: got %0d want 51", s, done); end
         vectors++;
         if (o_ovr !== 16'(STATS_ON ? s : 0) || o_flag !== 1'b0) begin
            errors++; $display("FAIL overrun_cnt s%0d: cnt=%0d flag=%b want %0d/0", s, o_ovr, o_flag, (STATS_ON ? s : 0));
         end
      end
   endtask

   task automatic test_clr_overrun();
      int gap, jdg, done, hi;
      logic wrm;
      do_sample(37, 45, 50, -1, -1, 39, 60, gap, jdg, done, hi, wrm);
      vectors++;
      if (gap !== 80 || jdg !== 51) begin
         errors++; $display("FAIL clr_overrun_trace: gap=%0d judge=%0d want 80/51", gap, jdg);
      end
      vectors++;
      if (o_ovr !== 16'd0) begin errors++; $display("FAIL clr_overrun_cnt: got %0d want 0", o_ovr); end
   endtask

   task automatic test_async_reset();
      int gap, jdg, done, hi;
      logic wrm;
      use_b = 1'b0;
      set_enable(1'b1);
      prev_adc = cyc;
      do_sample(20, -1, -1, -1, -1, -1, 160, gap, jdg, done, hi, wrm);
      vectors++;
      if (done !== 150 || o_flag !== 1'b1 || o_tmo !== 16'(STATS_ON ? 1 : 0)) begin
         errors++; $display("FAIL rst_pre_abort: done=%0d flag=%b tmo=%0d want 150/1/%0d", done, o_flag, o_tmo, (STATS_ON ? 1 : 0));
      end
      do_sample(20, 25, -1, -1, -1, -1, 40, gap, jdg, done, hi, wrm);
      vectors++;
      if (gap !== 200 || o_busy !== 1'b1) begin
         errors++; $display("FAIL rst_pre_busy: gap=%0d busy=%b want 200/1", gap, o_busy);
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({ifa.en_adc, ifa.en_judge, ifa.busy, ifa.warm, ifa.timeout_flag} !== 5'b0 ||
          ifa.overrun_cnt !== 16'd0 || ifa.timeout_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rst_async_a: adc=%b judge=%b busy=%b warm=%b flag=%b tmo=%0d, want all 0",
                  ifa.en_adc, ifa.en_judge, ifa.busy, ifa.warm, ifa.timeout_flag, ifa.timeout_cnt);
      end
      vectors++;
      if ({ifb.busy, ifb.warm, ifb.timeout_flag} !== 3'b0 || ifb.overrun_cnt !== 16'd0) begin
         errors++; $display("FAIL rst_async_b: busy=%b warm=%b flag=%b ovr=%0d, want all 0",
                            ifb.busy, ifb.warm, ifb.timeout_flag, ifb.overrun_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      ifa.enable = 1'b0; ifa.clr_stats = 1'b0;
      ifa.adc_finish = 1'b0; ifa.filter_finish = 1'b0; ifa.dif_finish = 1'b0;
      ifb.enable = 1'b0; ifb.clr_stats = 1'b0;
      ifb.adc_finish = 1'b0; ifb.filter_finish = 1'b0; ifb.dif_finish = 1'b0;
      test_reset();
      test_nominal();
      test_stall();
      test_spurious();
      test_enable_drop();
      test_overrun();
      test_clr_overrun();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not complete within time limit");
      $fatal(1, "time limit");
   end

endmodule
